// File: rtl/btn_pause_ctrl_pkg.sv
// rtl/btn_pause_ctrl_pkg.sv - shared state encoding and default timing for the pause button block
package btn_pause_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        HELD         = 2'd2,
        WAIT_RELEASE = 2'd3
    } btn_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 200000;
    localparam int DEFAULT_TICK_DIV        = 25000000;

endpackage

// File: rtl/btn_sync2.sv
// rtl/btn_sync2.sv - two-flop synchronizer for an asynchronous button input
module btn_sync2 (
    input  logic clk,
    input  logic rs,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/btn_pause_ctrl.sv
// rtl/btn_pause_ctrl.sv - debounced pause toggle and pausable step-tick divider for an LED chaser
module btn_pause_ctrl
    import btn_pause_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rs,
    input  logic btn_in,
    output logic pause,
    output logic tick,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic             btn_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pause_q, pause_d;
    logic             tick_q, tick_d;
    logic             press_q, press_d;
    logic             run;

    btn_sync2 u_sync (
        .clk (clk),
        .rs  (rs),
        .d   (btn_in),
        .q   (btn_s)
    );

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            pause_q <= 1'b0;
            tick_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pause_q <= pause_d;
            tick_q  <= tick_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT_RELEASE: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The divider only advances when pause is low now and stays low next cycle,
    // so a pause landing on a wrap edge swallows that tick and freezes div at its max.
    always_comb begin
        press_d = (state_q == WAIT_PRESS) && btn_s && (cnt_q == CNT_MAX);
        pause_d = pause_q ^ press_d;
        run     = !pause_q && !pause_d;
        div_d   = div_q;
        tick_d  = 1'b0;
        if (run) begin
            tick_d = (div_q == DIV_MAX);
            div_d  = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        end
    end

    assign pause = pause_q;
    assign tick  = tick_q;
    assign press = press_q;

endmodule

// File: tb/tb_btn_pause_ctrl.sv
// tb/tb_btn_pause_ctrl.sv - scoreboard bench for btn_pause_ctrl with hand-timed press and tick events
module tb_btn_pause_ctrl;

    typedef struct packed {
        logic is_press;
        int   cyc;
        logic pause;
    } ev_t;

    logic clk;
    logic rs;
    logic btn_in;
    logic pause;
    logic tick;
    logic press;

    int   cyc;
    bit   run;
    int   total;
    int   bad;
    ev_t  exp_q[$];

    btn_pause_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .TICK_DIV        (5)
    ) dut (
        .clk    (clk),
        .rs     (rs),
        .btn_in (btn_in),
        .pause  (pause),
        .tick   (tick),
        .press  (press)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic void expect_ev(input logic is_press, input int c, input logic pz);
        ev_t e;
        e.is_press = is_press;
        e.cyc      = c;
        e.pause    = pz;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(input logic is_press);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: seen at cycle %0d, required none", is_press ? "press" : "tick", cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_press !== is_press || e.cyc != cyc || e.pause !== pause) begin
                bad++;
                $display("FAIL event_%0d: got %s cyc=%0d pause=%0b, required %s cyc=%0d pause=%0b",
                         e.cyc, is_press ? "press" : "tick", cyc, pause,
                         e.is_press ? "press" : "tick", e.cyc, e.pause);
            end
        end
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        rs     = 1'b0;
        btn_in = 1'b0;
        cyc    = 0;
        run    = 1'b0;
        total  = 0;
        bad    = 0;

        fork
            forever begin
                @(posedge clk);
                if (run) cyc++;
            end
            forever begin
                @(negedge clk);
                if (run) begin
                    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                        total++;
                        bad++;
                        $display("FAIL missing_%s: required at cycle %0d, not seen by cycle %0d",
                                 exp_q[0].is_press ? "press" : "tick", exp_q[0].cyc, cyc);
                        void'(exp_q.pop_front());
                    end
                    if (press) check_ev(1'b1);
                    if (tick)  check_ev(1'b0);
                end
            end
            begin
                #20000;
                $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
                $fatal(1, "watchdog expired");
            end
        join_none

        // Mid-cycle asynchronous reset, outputs must clear without a clock edge
        #15 rs = 1'b1;
        #7;
        chk("reset_pause", pause, 1'b0);
        chk("reset_tick",  tick,  1'b0);
        chk("reset_press", press, 1'b0);
        #3 rs = 1'b0;
        run = 1'b1;

        for (int t = 5; t <= 25; t += 5) expect_ev(1'b0, t, 1'b0);
        expect_ev(1'b1, 26, 1'b1);

        wait_cyc(20); btn_in = 1'b1;
        wait_cyc(40); btn_in = 1'b0;

        // Bounce 1,0,1,0 then a steady press
        wait_cyc(50);
        expect_ev(1'b1, 60, 1'b0);
        for (int t = 65; t <= 75; t += 5) expect_ev(1'b0, t, 1'b0);
        btn_in = 1'b1;
        wait_cyc(51); btn_in = 1'b0;
        wait_cyc(52); btn_in = 1'b1;
        wait_cyc(53); btn_in = 1'b0;
        wait_cyc(54); btn_in = 1'b1;
        wait_cyc(62); btn_in = 1'b0;

        // Pause entered with div=2, 2-cycle release glitch while held, then unpause
        wait_cyc(72);
        expect_ev(1'b1, 78, 1'b1);
        expect_ev(1'b1, 108, 1'b0);
        for (int t = 111; t <= 121; t += 5) expect_ev(1'b0, t, 1'b0);
        btn_in = 1'b1;
        wait_cyc(80);  btn_in = 1'b0;
        wait_cyc(82);  btn_in = 1'b1;
        wait_cyc(88);  btn_in = 1'b0;
        wait_cyc(102); btn_in = 1'b1;
        wait_cyc(110); btn_in = 1'b0;

        // Reset while WAIT_PRESS has cnt=2, button kept high throughout
        wait_cyc(120); btn_in = 1'b1;
        wait_cyc(124);
        expect_ev(1'b0, 129, 1'b0);
        expect_ev(1'b1, 130, 1'b1);
        #2 rs = 1'b1;
        #2;
        chk("midrun_reset_pause", pause, 1'b0);
        chk("midrun_reset_tick",  tick,  1'b0);
        chk("midrun_reset_press", press, 1'b0);
        #2 rs = 1'b0;

        wait_cyc(140);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_events: got %0d unmatched, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_pause_ctrl.md
BTN_PAUSE_CTRL -- requirements
Module: btn_pause_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 200000: consecutive stable synchronized samples needed to accept a press or a release (legal range 2 or more).
REQ-002 The block SHALL have parameter TICK_DIV, default 25000000: clk cycles per step tick (legal range 2 or more).
REQ-003 Port clk, input, 1 bit: the single system clock; all state SHALL be updated on its rising edge.
REQ-004 Port rs, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port btn_in, input, 1 bit: raw pushbutton, asynchronous to clk, bouncy, 1 = pressed.
REQ-006 Port pause, output, 1 bit: registered pause level driving the downstream LED chaser's pause input; 1 = hold.
REQ-007 Port tick, output, 1 bit: registered one-cycle step enable for the downstream chaser.
REQ-008 Port press, output, 1 bit: registered one-cycle pulse per accepted press.

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer; btn_s is its output, and only btn_s SHALL be used by the logic.
REQ-010 The debounce FSM SHALL have exactly four states: IDLE, WAIT_PRESS, HELD, WAIT_RELEASE.
- IDLE with btn_s=1 goes to WAIT_PRESS with cnt=1.
- WAIT_PRESS with btn_s=0 goes to IDLE with cnt=0.
- WAIT_PRESS with btn_s=1 and cnt=DEBOUNCE_CYCLES-1 goes to HELD.
- WAIT_PRESS with btn_s=1 otherwise increments cnt.
- HELD with btn_s=0 goes to WAIT_RELEASE with cnt=1.
- WAIT_RELEASE with btn_s=1 goes to HELD with cnt=0.
- WAIT_RELEASE with btn_s=0 and cnt=DEBOUNCE_CYCLES-1 goes to IDLE.
- WAIT_RELEASE with btn_s=0 otherwise increments cnt.
REQ-011 On the WAIT_PRESS-to-HELD transition, press SHALL be 1 and pause SHALL toggle, both on the same edge; press SHALL be 0 on every other cycle.
REQ-012 With a clean step on btn_in, press SHALL first be high after the (DEBOUNCE_CYCLES+2)th rising edge following the step.
REQ-013 A held button SHALL produce exactly one press. No press SHALL occur until the full release is debounced and IDLE is re-entered.
REQ-014 cnt width SHALL be $clog2(DEBOUNCE_CYCLES); cnt SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-015 Tick divider behaviour:
- While pause=0, div SHALL count 0..TICK_DIV-1 and wrap to 0.
- tick SHALL be 1 for exactly the cycle after div equals TICK_DIV-1.
- div width SHALL be $clog2(TICK_DIV).
REQ-016 While pause=1, div SHALL hold its value and tick SHALL be 0. When pause returns to 0, counting SHALL resume from the held value, with no restart or extra tick.
REQ-017 If pause toggles to 1 on the same edge a tick would be generated, the tick SHALL be suppressed and div SHALL hold at TICK_DIV-1.
REQ-018 Tick period with pause=0 SHALL be exactly TICK_DIV cycles.

Reset
REQ-019 Asserting rs SHALL immediately (no clock required) force:
- both synchronizer flops, FSM state, cnt and div to 0 / IDLE;
- pause=0, tick=0, press=0.
REQ-020 rs asserted mid-debounce or mid-hold SHALL discard progress. After rs deasserts with btn_in held high, the block SHALL run a full fresh press debounce and produce one press.
REQ-021 All state SHALL leave reset on the first rising clk edge after rs falls.

Structure
REQ-022 A shared package SHALL hold the FSM state enum (2-bit: IDLE=0, WAIT_PRESS=1, HELD=2, WAIT_RELEASE=3) and the default DEBOUNCE_CYCLES and TICK_DIV constants.
REQ-023 The synchronizer SHALL be a separate sub-module, btn_sync2, with ports clk, rs, d, q, reused for any other button inputs. The FSM and the divider SHALL stay in btn_pause_ctrl.

Verification (bench parameters: DEBOUNCE_CYCLES=4, TICK_DIV=5, clk period 20 ns)
REQ-024 Reset: rs=1 for 10 ns mid-cycle -> pause, tick and press are 0 before the next edge; after release, tick is high on the cycle following the 5th edge, then every 5 cycles.
REQ-025 Clean press: btn_in 0->1 and held 20 cycles -> exactly one press pulse, after edge 6, and pause goes 0->1 on the same edge.
REQ-026 Bounce: btn_in toggled 1,0,1,0 at 1-cycle spacing, then held 1 -> no press during the bounce; one press 6 edges after the final rise.
REQ-027 Pause freeze: pause set while div=2, held 30 cycles, then a second press -> tick is 0 for the whole pause; the first tick after resume comes 3 cycles after div restarts counting.
REQ-028 Release debounce: a glitch of btn_s to 0 for 2 cycles while HELD -> state returns to HELD with no press; a real release held 4 or more cycles -> IDLE, and the next press toggles pause back to 0.
REQ-029 Reset during WAIT_PRESS: rs pulsed when cnt=2 with btn_in held 1 -> no press before reset; one press 6 edges after rs falls.
